// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and issues word reads to instruction memory
// (req/gnt + in-order rvalid). Returned words go into a prefetch FIFO and are handed
// to decode with valid/ready. A redirect flushes the FIFO, restarts fetch at the new
// PC and drops every response still in flight.
// Optional feature: define FETCH_STALL_CNT_EN to add the stall_cnt output, which counts
// cycles where decode was ready but no instruction was available.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    // Pointer width for the FIFO and counter width wide enough to hold FIFO_DEPTH.
    // MAX_OUTSTANDING never exceeds FIFO_DEPTH, so the same counter width fits it.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    localparam logic [CW-1:0] MAX_OUT_C  = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] DEPTH_S    = SW'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_reg,    fetch_pc_next;
    logic [31:0]   resp_pc_reg,     resp_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg,     discard_next;
    logic [CW-1:0] count_reg,       count_next;
    logic [AW-1:0] wr_ptr_reg,      wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg,      rd_ptr_next;

    // Per-cycle events
    logic issue_ok;
    logic grant;
    logic resp;
    logic drop;
    logic push;
    logic pop;

    // FIFO slot contents, gathered from the per-slot registers below
    logic [31:0] slot_pc    [FIFO_DEPTH];
    logic [31:0] slot_instr [FIFO_DEPTH];

    // Credit rule: a new request is only issued when both the outstanding limit
    // and the FIFO space (counting words still in flight) allow it, so every
    // response is guaranteed a slot.
    assign issue_ok = (outstanding_reg < MAX_OUT_C) &&
                      ((SW'(outstanding_reg) + SW'(count_reg)) < DEPTH_S);
    assign imem_req  = !reset && !redirect && issue_ok;
    assign imem_addr = fetch_pc_reg;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding is ignored entirely.
    assign resp = imem_rvalid && (outstanding_reg != '0);
    assign drop = resp && (discard_reg != '0);
    // A response arriving in a redirect cycle is stale and never enters the FIFO.
    assign push = resp && !drop && !redirect;

    // First-word-fall-through output; data is forced to zero while empty.
    assign dec_valid = (count_reg != '0);
    assign dec_instr = dec_valid ? slot_instr[rd_ptr_reg] : '0;
    assign dec_pc    = dec_valid ? slot_pc[rd_ptr_reg]    : '0;
    assign pop       = dec_valid && dec_ready;

    // FIFO storage: one register pair per slot, written when the write pointer selects it
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [31:0] pc_reg;
            logic [31:0] instr_reg;

            // Capture the returning word and its PC into this slot
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    pc_reg    <= resp_pc_reg;
                    instr_reg <= imem_rdata;
                end
            end

            assign slot_pc[gi]    = pc_reg;
            assign slot_instr[gi] = instr_reg;
        end
    endgenerate

    // Next-state logic; redirect overrides every other update in its cycle
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg + CW'(grant) - CW'(resp);
        discard_next     = discard_reg;
        count_next       = count_reg + CW'(push) - CW'(pop);
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;

        if (grant) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        if (push) begin
            resp_pc_next = resp_pc_reg + 32'd4;
            wr_ptr_next  = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (drop) begin
            discard_next = discard_reg - CW'(1);
        end

        if (redirect) begin
            fetch_pc_next = redirect_pc;
            resp_pc_next  = redirect_pc;
            // No grant can happen this cycle, so whatever is still in flight
            // after this cycle's response (if any) is stale and must be dropped.
            discard_next  = outstanding_reg - CW'(resp);
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            count_reg       <= count_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of cycles where decode waited on an empty fetch buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (dec_ready && !dec_valid && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

`ifndef SYNTHESIS
    // A response with no request outstanding means the memory side is misbehaving
    no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (outstanding_reg == '0)));
`endif

endmodule
